// File: rtl/fb_line_fetcher_pkg.sv
// Shared definitions for the framebuffer line fetcher: FSM encodings, bus widths,
// the default framebuffer base address and the pixels-per-word helper.
package fb_line_fetcher_pkg;

    localparam int BUS_AW = 24;
    localparam int BUS_DW = 32;

    localparam logic [BUS_AW-1:0] FB_BASE_DEFAULT = 24'h100000;

    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE  = 3'd0;
    localparam fsm_state_t ST_FETCH = 3'd1;
    localparam fsm_state_t ST_WAIT  = 3'd2;
    localparam fsm_state_t ST_FLUSH = 3'd3;
    localparam fsm_state_t ST_DONE  = 3'd4;

    function automatic int pix_per_word(input int pix_bits);
        return BUS_DW / pix_bits;
    endfunction

endpackage

// File: rtl/fb_line_fetcher_if.sv
// Read port between the line fetcher (master) and bus_arbiter port 1 (slave).
interface fb_line_fetcher_if;
    import fb_line_fetcher_pkg::*;

    logic [BUS_AW-1:0] addr1;
    logic              req_read1;
    logic [BUS_DW-1:0] data1;
    logic              data_valid1;

    modport master (output addr1, output req_read1, input data1, input data_valid1);
    modport slave  (input addr1, input req_read1, output data1, output data_valid1);

endinterface

// File: rtl/fb_line_fetcher_word_fifo.sv
// fb_word_fifo: 32-bit synchronous word FIFO with show-ahead dout and synchronous clear.
module fb_word_fifo
    import fb_line_fetcher_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [BUS_DW-1:0]          din,
    output logic [BUS_DW-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [BUS_DW-1:0] mem_q [DEPTH];
    logic [BUS_DW-1:0] mem_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fb_line_fetcher.sv
// Streams a packed framebuffer from SDRAM (arbiter port 1) into a pixel stream, LSB pixel first.
// Define FB_FETCH_STATS_EN to add underflow_count and max_wait statistics outputs.
//   state | meaning
//   IDLE  | after reset, waiting for frame_start
//   FETCH | one read per visit; req_read1 low for one cycle, then high until data_valid1
//   WAIT  | FIFO full, waiting for the unpacker to free an entry
//   FLUSH | frame_start hit an outstanding read; hold it, discard its word, restart at FB_BASE
//   DONE  | all frame words returned, waiting for frame_start
module fb_line_fetcher
    import fb_line_fetcher_pkg::*;
#(
    parameter logic [BUS_AW-1:0] FB_BASE        = FB_BASE_DEFAULT,
    parameter int                WORDS_PER_LINE = 80,
    parameter int                LINES          = 240,
    parameter int                FIFO_DEPTH     = 16,
    parameter int                PIX_BITS       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic                pix_req,
    output logic [PIX_BITS-1:0] pix_data,
    output logic                pix_valid,
    output logic                underflow,
    output logic                frame_done,
`ifdef FB_FETCH_STATS_EN
    output logic [15:0]         underflow_count,
    output logic [7:0]          max_wait,
`endif
    fb_line_fetcher_if.master   bus
);

    localparam int TOTAL_WORDS = LINES * WORDS_PER_LINE;
    localparam int WL_W        = $clog2(TOTAL_WORDS + 1);
    localparam int PPW         = pix_per_word(PIX_BITS);
    localparam int PC_W        = $clog2(PPW + 1);
    localparam int FC_W        = $clog2(FIFO_DEPTH + 1);

    fsm_state_t          state_q, state_d;
    logic                req_q, req_d;
    logic [BUS_AW-1:0]   addr_q, addr_d;
    logic [WL_W-1:0]     words_left_q, words_left_d;
    logic                frame_done_q, frame_done_d;
    logic [BUS_DW-1:0]   shift_q, shift_d;
    logic [PC_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic                pix_valid_q, pix_valid_d;
    logic [PIX_BITS-1:0] pix_data_q, pix_data_d;
    logic                underflow_q, underflow_d;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_fills;
    logic [BUS_DW-1:0]   fifo_dout;
    logic [FC_W-1:0]     fifo_count;
    logic                consume;
    logic [BUS_DW-1:0]   shift_nx;
    logic [PC_W-1:0]     cnt_nx;

    fb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_start),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.data1),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The push that fills the last entry parks the FSM in WAIT unless the unpacker pops alongside it.
    assign fifo_fills = (fifo_count == FC_W'(FIFO_DEPTH - 1)) && !fifo_pop;

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        fifo_push    = 1'b0;
        case (state_q)
            ST_IDLE, ST_WAIT, ST_DONE: begin
                if (frame_start) begin
                    state_d      = ST_FETCH;
                    addr_d       = FB_BASE;
                    words_left_d = WL_W'(TOTAL_WORDS);
                end else if (state_q == ST_WAIT && !fifo_full) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!req_q) begin
                    if (frame_start) begin
                        addr_d       = FB_BASE;
                        words_left_d = WL_W'(TOTAL_WORDS);
                    end else begin
                        req_d = 1'b1;
                    end
                end else if (frame_start) begin
                    words_left_d = WL_W'(TOTAL_WORDS);
                    if (bus.data_valid1) begin
                        // Read completes on the restart edge: drop its word, no flush needed.
                        req_d  = 1'b0;
                        addr_d = FB_BASE;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else if (bus.data_valid1) begin
                    req_d        = 1'b0;
                    fifo_push    = 1'b1;
                    addr_d       = addr_q + 24'd1;
                    words_left_d = words_left_q - 1'b1;
                    if (words_left_q == WL_W'(1)) begin
                        state_d = ST_DONE;
                    end else if (fifo_fills) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_FLUSH: begin
                if (bus.data_valid1) begin
                    req_d        = 1'b0;
                    state_d      = ST_FETCH;
                    addr_d       = FB_BASE;
                    words_left_d = WL_W'(TOTAL_WORDS);
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
        frame_done_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    end

    // Unpacker: reload in the same cycle the last pixel leaves so the stream stays gapless.
    always_comb begin
        consume   = pix_req && pix_valid_q;
        shift_nx  = consume ? (shift_q >> PIX_BITS) : shift_q;
        cnt_nx    = pix_cnt_q - PC_W'(consume);
        fifo_pop  = 1'b0;
        shift_d   = shift_nx;
        pix_cnt_d = cnt_nx;
        if (frame_start) begin
            shift_d   = '0;
            pix_cnt_d = '0;
        end else if (cnt_nx == '0 && !fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_dout;
            pix_cnt_d = PC_W'(PPW);
        end
        pix_valid_d = (pix_cnt_d != '0);
        pix_data_d  = pix_valid_d ? shift_d[PIX_BITS-1:0] : '0;
        underflow_d = frame_start ? 1'b0 : (underflow_q || (pix_req && !pix_valid_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            addr_q       <= FB_BASE;
            words_left_q <= '0;
            frame_done_q <= 1'b1;
            shift_q      <= '0;
            pix_cnt_q    <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            frame_done_q <= frame_done_d;
            shift_q      <= shift_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_valid_q  <= pix_valid_d;
            pix_data_q   <= pix_data_d;
            underflow_q  <= underflow_d;
        end
    end

    assign bus.addr1     = addr_q;
    assign bus.req_read1 = req_q;
    assign pix_data      = pix_data_q;
    assign pix_valid     = pix_valid_q;
    assign underflow     = underflow_q;
    assign frame_done    = frame_done_q;

`ifdef FB_FETCH_STATS_EN
    logic [15:0] uf_cnt_q, uf_cnt_d;
    logic [7:0]  cur_wait_q, cur_wait_d;
    logic [7:0]  max_wait_q, max_wait_d;
    logic [7:0]  lat_now;

    // Latency counts every cycle req_read1 is high, including the strobe cycle.
    always_comb begin
        uf_cnt_d   = uf_cnt_q;
        max_wait_d = max_wait_q;
        lat_now    = (cur_wait_q == 8'hFF) ? 8'hFF : (cur_wait_q + 8'd1);
        cur_wait_d = (req_q && !bus.data_valid1) ? lat_now : 8'd0;
        if (frame_start) begin
            uf_cnt_d   = '0;
            max_wait_d = '0;
        end else begin
            if (pix_req && !pix_valid_q && uf_cnt_q != 16'hFFFF) begin
                uf_cnt_d = uf_cnt_q + 16'd1;
            end
            if (req_q && bus.data_valid1 && lat_now > max_wait_q) begin
                max_wait_d = lat_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uf_cnt_q   <= '0;
            cur_wait_q <= '0;
            max_wait_q <= '0;
        end else begin
            uf_cnt_q   <= uf_cnt_d;
            cur_wait_q <= cur_wait_d;
            max_wait_q <= max_wait_d;
        end
    end

    assign underflow_count = uf_cnt_q;
    assign max_wait        = max_wait_q;
`endif

endmodule

// File: tb/tb_fb_line_fetcher.sv
// Randomized scoreboard bench for fb_line_fetcher with a behavioural arbiter/memory model.
module tb_fb_line_fetcher;

    localparam int          WPL   = 4;
    localparam int          LINES = 3;
    localparam int          TOTAL = WPL * LINES;
    localparam int          FD    = 4;
    localparam int          PB    = 4;
    localparam int          PPW   = 32 / PB;
    localparam logic [23:0] BASE  = 24'h100000;

    logic          clk, rst_n, frame_start, pix_req;
    logic [PB-1:0] pix_data;
    logic          pix_valid, underflow, frame_done;
`ifdef FB_FETCH_STATS_EN
    logic [15:0]   underflow_count;
    logic [7:0]    max_wait;
`endif

    fb_line_fetcher_if bus_if ();

    fb_line_fetcher #(
        .FB_BASE        (BASE),
        .WORDS_PER_LINE (WPL),
        .LINES          (LINES),
        .FIFO_DEPTH     (FD),
        .PIX_BITS       (PB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .pix_req         (pix_req),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .underflow       (underflow),
        .frame_done      (frame_done),
`ifdef FB_FETCH_STATS_EN
        .underflow_count (underflow_count),
        .max_wait        (max_wait),
`endif
        .bus             (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0]   mem [TOTAL];
    logic [PB-1:0] exp_q [$];
    int  lat_min, lat_max, req_pct;
    bit  fs_req;
    int  n_done, n_req, exp_idx;
    bit  exp_uf;
    int  uf_events;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Arbiter + memory model; drives all DUT inputs 1 time unit after each rising edge.
    initial begin : driver
        logic [23:0] req_addr;
        logic [31:0] word;
        int  wcnt, lat_cur;
        bit  outstanding, discard, dv_prev, fs_now, dv_now;
        outstanding = 0; discard = 0; dv_prev = 0; wcnt = 0; lat_cur = 0; req_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                outstanding = 0; discard = 0; dv_prev = 0; fs_req = 0;
                exp_idx = 0; n_done = 0; n_req = 0;
                frame_start = 0; bus_if.data_valid1 = 0; pix_req = 0;
                continue;
            end
            fs_now = fs_req;
            fs_req = 0;
            dv_now = 0;
            if (dv_prev) begin
                chk("req_drop", 32'(bus_if.req_read1), 32'd0);
            end else if (bus_if.req_read1) begin
                if (!outstanding) begin
                    outstanding = 1; wcnt = 0; n_req++;
                    lat_cur  = int'($urandom_range(lat_max, lat_min));
                    req_addr = bus_if.addr1;
                    chk("addr_seq", 32'(bus_if.addr1), 32'(BASE + 24'(exp_idx)));
                    exp_idx++;
                end else begin
                    chk("addr_stable", 32'(bus_if.addr1), 32'(req_addr));
                end
                wcnt++;
                if (wcnt >= lat_cur) begin
                    dv_now      = 1;
                    outstanding = 0;
                    word        = mem[int'(24'(req_addr - BASE)) % TOTAL];
                    bus_if.data1 = word;
                    if (discard || fs_now) begin
                        discard = 0;
                    end else begin
                        for (int i = 0; i < PPW; i++) exp_q.push_back(PB'(word >> (i * PB)));
                        n_done++;
                    end
                end
            end else if (outstanding) begin
                chk("req_held", 32'(bus_if.req_read1), 32'd1);
                outstanding = 0;
            end
            if (fs_now) begin
                exp_idx = 0; n_done = 0; n_req = 0;
                if (bus_if.req_read1 && !dv_now && !dv_prev) discard = 1;
            end
            frame_start        = fs_now;
            bus_if.data_valid1 = dv_now;
            dv_prev            = dv_now;
            pix_req            = (int'($urandom_range(99, 0)) < req_pct);
        end
    end

    // Monitor: pops the expected pixel whenever the consumer takes one; tracks sticky underflow.
    initial begin : monitor
        logic [PB-1:0] exp_pix;
        exp_uf = 0; uf_events = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete(); exp_uf = 0; uf_events = 0;
                continue;
            end
            chk("underflow", 32'(underflow), 32'(exp_uf));
            if (pix_valid) begin
                if (pix_req) begin
                    if (exp_q.size() == 0) begin
                        chk("stale_pixel", 32'(pix_data), 32'hFFFF_FFFF);
                    end else begin
                        exp_pix = exp_q.pop_front();
                        chk("pixel", 32'(pix_data), 32'(exp_pix));
                    end
                end
            end else begin
                chk("idle_pix_zero", 32'(pix_data), 32'd0);
                if (pix_req) begin
                    exp_uf = 1;
                    uf_events++;
                end
            end
            if (frame_start) begin
                exp_q.delete(); exp_uf = 0; uf_events = 0;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic start_frame();
        @(negedge clk);
        fs_req = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_frame_done(input string name, input int limit);
        int k;
        k = 0;
        while (!(frame_done && n_done == TOTAL) && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_frame_done"}, 32'(frame_done), 32'd1);
        chk({name, "_reads"}, 32'(n_done), 32'(TOTAL));
    endtask

    initial begin : main
        int k, saved;
        for (int i = 0; i < TOTAL; i++) mem[i] = $urandom;
        mem[0] = 32'h76543210;
        lat_min = 3; lat_max = 3; req_pct = 0; fs_req = 0;
        frame_start = 0; pix_req = 0; bus_if.data1 = '0; bus_if.data_valid1 = 0;
        rst_n = 1;
        #3 rst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(bus_if.req_read1), 32'd0);
        chk("rst_addr", 32'(bus_if.addr1), 32'(BASE));
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd1);
        @(negedge clk); #2 rst_n = 1;
        repeat (2) @(negedge clk);

        // Consumer idle: shifter plus FIFO fill, then the fetcher parks.
        start_frame();
        k = 0;
        while (n_done < FD + 1 && k < 300) begin @(negedge clk); k++; end
        repeat (20) @(negedge clk);
        chk("fill_reads", 32'(n_done), 32'(FD + 1));
        chk("wait_req_low", 32'(bus_if.req_read1), 32'd0);
        chk("fill_not_done", 32'(frame_done), 32'd0);
        saved = n_req;
        req_pct = 100;
        repeat (8) @(negedge clk);
        req_pct = 0;
        k = 0;
        while (n_req == saved && k < 50) begin @(negedge clk); k++; end
        chk("resume_req", 32'(n_req > saved), 32'd1);
        lat_min = 1; lat_max = 4; req_pct = 50;
        wait_frame_done("frame1", 3000);
        saved = n_req;
        repeat (20) @(negedge clk);
        chk("done_no_req", 32'(n_req), 32'(saved));
        chk("done_req_low", 32'(bus_if.req_read1), 32'd0);
        req_pct = 100;
        k = 0;
        while ((pix_valid || exp_q.size() != 0) && k < 300) begin @(negedge clk); k++; end
        chk("drained_queue", 32'(exp_q.size()), 32'd0);

        // frame_start just after a request rises: flush, then restart at the base.
        lat_min = 6; lat_max = 6; req_pct = 30;
        start_frame();
        k = 0;
        while (n_done < 3 && k < 300) begin @(negedge clk); k++; end
        while (bus_if.req_read1 && k < 400) begin @(negedge clk); k++; end
        while (!bus_if.req_read1 && k < 500) begin @(negedge clk); k++; end
        chk("flush_setup", 32'(bus_if.req_read1), 32'd1);
        fs_req = 1;
        lat_min = 1; lat_max = 5;
        repeat (2) @(negedge clk);
        req_pct = 60;
        wait_frame_done("flush", 3000);

        // Long stall with the consumer asking every cycle.
        lat_min = 50; lat_max = 50; req_pct = 100;
        start_frame();
        repeat (40) @(negedge clk);
        #2;
        chk("stall_underflow", 32'(underflow), 32'd1);
        chk("stall_pix_valid", 32'(pix_valid), 32'd0);
        chk("stall_pix_data", 32'(pix_data), 32'd0);
`ifdef FB_FETCH_STATS_EN
        chk("stall_uf_count", 32'(underflow_count), 32'(uf_events - ((pix_req && !pix_valid) ? 1 : 0)));
`endif
        lat_min = 1; lat_max = 3; req_pct = 80;
        wait_frame_done("stall", 3000);

        // Reset while a read is outstanding.
        lat_min = 10; lat_max = 10; req_pct = 50;
        start_frame();
        k = 0;
        while (!bus_if.req_read1 && k < 50) begin @(negedge clk); k++; end
        chk("rst_mid_setup", 32'(bus_if.req_read1), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_req", 32'(bus_if.req_read1), 32'd0);
        chk("rst_mid_addr", 32'(bus_if.addr1), 32'(BASE));
        chk("rst_mid_done", 32'(frame_done), 32'd1);
        chk("rst_mid_valid", 32'(pix_valid), 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1;
        lat_min = 1; lat_max = 2; req_pct = 70;
        start_frame();
        wait_frame_done("post_rst", 3000);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
